// File: rtl/prio_enqueue_demux.sv
// Strict-priority ingress demux: routes whole AXI-Stream packets to one of
// NUM_FIFO per-priority queues, dropping packets whose queue is almost-full.
module prio_enqueue_demux #(
   parameter int NUM_FIFO   = 3,
   parameter int SEL_WIDTH  = $clog2(NUM_FIFO),
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int PRIO_WIDTH = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic [PRIO_WIDTH-1:0]          s_axis_tuser,
   output logic [NUM_FIFO*DATA_WIDTH-1:0] m_axis_tdata,
   output logic [NUM_FIFO*KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [NUM_FIFO-1:0]            m_axis_tvalid,
   input  logic [NUM_FIFO-1:0]            m_axis_tready,
   output logic [NUM_FIFO-1:0]            m_axis_tlast,
   input  logic [NUM_FIFO-1:0]            fifo_afull,
   output logic                           drop_pulse,
   output logic [SEL_WIDTH-1:0]           drop_queue,
   output logic [CNT_WIDTH-1:0]           drop_count
);

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t               state;
   logic [SEL_WIDTH-1:0] sel;
   logic [SEL_WIDTH-1:0] q;
   logic [SEL_WIDTH-1:0] tgt;
   logic                 slot_rdy;
   logic                 drop_hit;
   logic                 fwd_path;
   logic                 load;

   logic [DATA_WIDTH-1:0] data_r [NUM_FIFO];
   logic [KEEP_WIDTH-1:0] keep_r [NUM_FIFO];
   logic [NUM_FIFO-1:0]   vld_r;
   logic [NUM_FIFO-1:0]   last_r;

   // Out-of-range tags fall to the lowest-priority queue
   always_comb begin
      q = SEL_WIDTH'(NUM_FIFO - 1);
      if (32'(s_axis_tuser) < 32'(NUM_FIFO))
         q = SEL_WIDTH'(s_axis_tuser);
      tgt      = (state == IDLE) ? q : sel;
      slot_rdy = !vld_r[tgt] || m_axis_tready[tgt];
      drop_hit = (state == IDLE) && fifo_afull[q];
      fwd_path = (state == FWD) || ((state == IDLE) && !fifo_afull[q]);
      s_axis_tready = !rst && ((state == DROP) || drop_hit
                               || (fwd_path && slot_rdy));
      load = s_axis_tvalid && s_axis_tready && fwd_path;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= '0;
         drop_pulse <= 1'b0;
         drop_queue <= '0;
         drop_count <= '0;
      end else begin
         drop_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (s_axis_tvalid) begin
                  sel <= q;
                  if (drop_hit) begin
                     drop_pulse <= 1'b1;
                     drop_queue <= q;
                     if (drop_count != '1)
                        drop_count <= drop_count + CNT_WIDTH'(1);
                     state <= s_axis_tlast ? IDLE : DROP;
                  end else if (s_axis_tready) begin
                     state <= s_axis_tlast ? IDLE : FWD;
                  end
               end
            end
            FWD: begin
               if (s_axis_tvalid && s_axis_tready && s_axis_tlast)
                  state <= IDLE;
            end
            DROP: begin
               if (s_axis_tvalid && s_axis_tlast)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One register slot per queue; unselected slots keep draining
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r  <= '0;
         last_r <= '0;
      end else begin
         for (int i = 0; i < NUM_FIFO; i++) begin
            if (load && tgt == SEL_WIDTH'(i)) begin
               vld_r[i]  <= 1'b1;
               last_r[i] <= s_axis_tlast;
            end else if (m_axis_tready[i]) begin
               vld_r[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FIFO; i++) begin
         if (load && tgt == SEL_WIDTH'(i)) begin
            data_r[i] <= s_axis_tdata;
            keep_r[i] <= s_axis_tkeep;
         end
      end
   end

   for (genvar g = 0; g < NUM_FIFO; g++) begin : g_out
      assign m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH] = data_r[g];
      assign m_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH] = keep_r[g];
   end

   assign m_axis_tvalid = vld_r;
   assign m_axis_tlast  = last_r;

endmodule

// File: tb/tb_prio_enqueue_demux.sv
// Directed bench for prio_enqueue_demux: routing, drops, backpressure,
// mid-packet reset.
module tb_prio_enqueue_demux;

   logic         clk = 1'b0;
   logic         rst;
   logic [63:0]  s_tdata;
   logic [7:0]   s_tkeep;
   logic         s_tvalid;
   logic         s_tready;
   logic         s_tlast;
   logic [2:0]   s_tuser;
   logic [191:0] m_tdata;
   logic [23:0]  m_tkeep;
   logic [2:0]   m_tvalid;
   logic [2:0]   m_tready;
   logic [2:0]   m_tlast;
   logic [2:0]   afull;
   logic         drop_pulse;
   logic [1:0]   drop_queue;
   logic [31:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   prio_enqueue_demux dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .fifo_afull    (afull),
      .drop_pulse    (drop_pulse),
      .drop_queue    (drop_queue),
      .drop_count    (drop_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input logic [2:0] u,
                       input logic l);
      s_tdata  = d;
      s_tkeep  = 8'hff;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      #1;
   endtask

   task automatic idle_in();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = '0;
      m_tready = 3'b111;
      afull    = 3'b000;
      tick();
      tick();
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_count", 64'(drop_count), 64'd0);
      chk("rst_pulse", 64'(drop_pulse), 64'd0);
      rst = 1'b0;
      tick();

      // 1: four-beat packet to queue 1
      for (int i = 0; i < 4; i++) begin
         beat(64'h1000 + 64'(i), 3'd1, i == 3);
         chk("t1_tready", 64'(s_tready), 64'd1);
         tick();
         chk("t1_tvalid", 64'(m_tvalid), 64'b010);
         chk("t1_data", m_tdata[64 +: 64], 64'h1000 + 64'(i));
         chk("t1_last", 64'(m_tlast[1]), 64'(i == 3));
      end
      idle_in();
      tick();
      chk("t1_drained", 64'(m_tvalid), 64'd0);

      // 2: out-of-range tag then back-to-back SOP
      beat(64'h2222, 3'd5, 1'b1);
      chk("t2_tready", 64'(s_tready), 64'd1);
      tick();
      chk("t2_tvalid", 64'(m_tvalid), 64'b100);
      chk("t2_data", m_tdata[128 +: 64], 64'h2222);
      chk("t2_last", 64'(m_tlast[2]), 64'd1);
      beat(64'h2333, 3'd0, 1'b1);
      chk("t2_b2b_rdy", 64'(s_tready), 64'd1);
      tick();
      chk("t2_b2b_vld", 64'(m_tvalid), 64'b001);
      chk("t2_b2b_dat", m_tdata[0 +: 64], 64'h2333);
      idle_in();
      tick();

      // 3: drop on queue 0
      afull = 3'b001;
      for (int i = 0; i < 3; i++) begin
         beat(64'h3000 + 64'(i), 3'd0, i == 2);
         chk("t3_tready", 64'(s_tready), 64'd1);
         tick();
         chk("t3_tvalid", 64'(m_tvalid), 64'd0);
         chk("t3_pulse", 64'(drop_pulse), 64'(i == 0));
      end
      chk("t3_queue", 64'(drop_queue), 64'd0);
      chk("t3_count", 64'(drop_count), 64'd1);
      afull = 3'b000;
      idle_in();
      tick();
      chk("t3_pulse_off", 64'(drop_pulse), 64'd0);

      // 4: afull rises mid-packet, next packet dropped
      for (int i = 0; i < 3; i++) begin
         beat(64'h4000 + 64'(i), (i == 0) ? 3'd2 : 3'd0, i == 2);
         chk("t4_tready", 64'(s_tready), 64'd1);
         tick();
         if (i == 0) afull = 3'b100;
         chk("t4_tvalid", 64'(m_tvalid), 64'b100);
         chk("t4_data", m_tdata[128 +: 64], 64'h4000 + 64'(i));
      end
      chk("t4_last", 64'(m_tlast[2]), 64'd1);
      beat(64'h4444, 3'd2, 1'b1);
      chk("t4_drop_rdy", 64'(s_tready), 64'd1);
      tick();
      chk("t4_drop_vld", 64'(m_tvalid), 64'd0);
      chk("t4_pulse", 64'(drop_pulse), 64'd1);
      chk("t4_queue", 64'(drop_queue), 64'd2);
      chk("t4_count", 64'(drop_count), 64'd2);
      afull = 3'b000;
      idle_in();
      tick();

      // 5: backpressure on queue 1
      m_tready = 3'b101;
      beat(64'h5000, 3'd1, 1'b0);
      chk("t5_first_rdy", 64'(s_tready), 64'd1);
      tick();
      beat(64'h5001, 3'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("t5_stall_rdy", 64'(s_tready), 64'd0);
         chk("t5_hold_dat", m_tdata[64 +: 64], 64'h5000);
         chk("t5_hold_vld", 64'(m_tvalid), 64'b010);
         tick();
      end
      m_tready = 3'b111;
      #1;
      chk("t5_release", 64'(s_tready), 64'd1);
      for (int i = 1; i < 4; i++) begin
         if (i > 1) beat(64'h5000 + 64'(i), 3'd0, i == 3);
         tick();
         chk("t5_seq_vld", 64'(m_tvalid), 64'b010);
         chk("t5_seq_dat", m_tdata[64 +: 64], 64'h5000 + 64'(i));
      end
      chk("t5_last", 64'(m_tlast[1]), 64'd1);
      idle_in();
      tick();
      chk("t5_drained", 64'(m_tvalid), 64'd0);

      // 6: reset in the middle of a packet
      beat(64'h6000, 3'd0, 1'b0);
      tick();
      beat(64'h6001, 3'd0, 1'b0);
      tick();
      chk("t6_pre_vld", 64'(m_tvalid), 64'b001);
      rst = 1'b1;
      beat(64'h6002, 3'd0, 1'b0);
      chk("t6_rst_rdy", 64'(s_tready), 64'd0);
      tick();
      chk("t6_rst_vld", 64'(m_tvalid), 64'd0);
      chk("t6_rst_cnt", 64'(drop_count), 64'd0);
      chk("t6_rst_q", 64'(drop_queue), 64'd0);
      rst = 1'b0;
      beat(64'h6003, 3'd2, 1'b1);
      chk("t6_sop_rdy", 64'(s_tready), 64'd1);
      tick();
      chk("t6_sop_vld", 64'(m_tvalid), 64'b100);
      chk("t6_sop_dat", m_tdata[128 +: 64], 64'h6003);
      chk("t6_sop_last", 64'(m_tlast[2]), 64'd1);
      idle_in();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
